// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter: FSM encoding, port identifiers
// and default bus widths.
package mem_arb_pkg;

    localparam int BW_DEF = 16;
    localparam int AW_DEF = 9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_A  = 2'd1,
        ACC_B  = 2'd2,
        HOLD_B = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

endpackage

// File: rtl/mem_arb_if.sv
// Bundles the CPU port, loader port and main-memory bus of the arbiter.
// The master modport is the arbiter's view; slave is the requesters/memory view.
interface mem_arb_if #(
    parameter int BW = mem_arb_pkg::BW_DEF,
    parameter int AW = mem_arb_pkg::AW_DEF
) ();

    logic          req_a;
    logic          we_a;
    logic [AW-1:0] addr_a;
    logic [BW-1:0] wdata_a;
    logic          gnt_a;
    logic          rvalid_a;
    logic [BW-1:0] rdata_a;

    logic          req_b;
    logic          we_b;
    logic          lock_b;
    logic [AW-1:0] addr_b;
    logic [BW-1:0] wdata_b;
    logic          gnt_b;
    logic          rvalid_b;
    logic [BW-1:0] rdata_b;

    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data;
    logic          mem_wren;
    logic [BW-1:0] mem_q;

    modport master (
        input  req_a, we_a, addr_a, wdata_a,
        output gnt_a, rvalid_a, rdata_a,
        input  req_b, we_b, lock_b, addr_b, wdata_b,
        output gnt_b, rvalid_b, rdata_b,
        output mem_addr, mem_data, mem_wren,
        input  mem_q
    );

    modport slave (
        output req_a, we_a, addr_a, wdata_a,
        input  gnt_a, rvalid_a, rdata_a,
        output req_b, we_b, lock_b, addr_b, wdata_b,
        input  gnt_b, rvalid_b, rdata_b,
        input  mem_addr, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single synchronous main memory,
// with a bounded locked-burst mode for the loader port B.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int BW        = BW_DEF,
    parameter int AW        = AW_DEF,
    parameter int MAX_BURST = 8
) (
    input  logic     clk,
    input  logic     rstn,
    mem_arb_if.master bus
);

    localparam int CW = $clog2(MAX_BURST + 1);

    arb_state_t    state;
    arb_state_t    state_next;
    port_t         last_port;
    logic          grant_a;
    logic          grant_b;
    logic [AW-1:0] cap_addr;
    logic [BW-1:0] cap_data;
    logic          cap_we;
    logic [CW-1:0] burst_cnt;
    logic          rvalid_a_q;
    logic          rvalid_b_q;
    logic [BW-1:0] rdata_a_q;
    logic [BW-1:0] rdata_b_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request inputs are only looked at in IDLE and HOLD_B, never in a grant cycle.
    always_comb begin
        state_next = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_a && (!bus.req_b || last_port == PORT_B)) begin
                    grant_a    = 1'b1;
                    state_next = ACC_A;
                end else if (bus.req_b) begin
                    grant_b    = 1'b1;
                    state_next = ACC_B;
                end
            end
            ACC_A: state_next = IDLE;
            ACC_B: begin
                if (bus.lock_b && burst_cnt < CW'(MAX_BURST)) begin
                    state_next = HOLD_B;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD_B: begin
                if (bus.req_b) begin
                    grant_b    = 1'b1;
                    state_next = ACC_B;
                end else if (!bus.lock_b) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_port  <= PORT_B;
            cap_addr   <= '0;
            cap_data   <= '0;
            cap_we     <= 1'b0;
            burst_cnt  <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            if (grant_a) begin
                cap_addr  <= bus.addr_a;
                cap_data  <= bus.wdata_a;
                cap_we    <= bus.we_a;
                last_port <= PORT_A;
            end else if (grant_b) begin
                cap_addr  <= bus.addr_b;
                cap_data  <= bus.wdata_b;
                cap_we    <= bus.we_b;
                last_port <= PORT_B;
            end
            if (state == IDLE) begin
                burst_cnt <= grant_b ? CW'(1) : '0;
            end else if (state == HOLD_B && grant_b) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
            rvalid_a_q <= (state == ACC_A) && !cap_we;
            rvalid_b_q <= (state == ACC_B) && !cap_we;
            if (rvalid_a_q) begin
                rdata_a_q <= bus.mem_q;
            end
            if (rvalid_b_q) begin
                rdata_b_q <= bus.mem_q;
            end
        end
    end

    // Read data passes straight through in the rvalid cycle, then holds.
    always_comb begin
        bus.gnt_a    = (state == ACC_A);
        bus.gnt_b    = (state == ACC_B);
        bus.mem_wren = ((state == ACC_A) || (state == ACC_B)) && cap_we;
        bus.mem_addr = cap_addr;
        bus.mem_data = cap_data;
        bus.rvalid_a = rvalid_a_q;
        bus.rvalid_b = rvalid_b_q;
        bus.rdata_a  = rvalid_a_q ? bus.mem_q : rdata_a_q;
        bus.rdata_b  = rvalid_b_q ? bus.mem_q : rdata_b_q;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter BW, default 16: data word width, equal to the MM data port width.
REQ-002 Parameter AW, default 9: address width, equal to the MM address port width.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive locked port-B accesses.
REQ-004 clk  in  1: single clock, shared with MM; all state changes on the rising edge.
REQ-005 rstn  in  1: reset, synchronous and active-low.
REQ-006 req_a, we_a  in  1 each: CPU port request and write-enable.
REQ-007 addr_a  in  AW, wdata_a  in  BW: CPU port address and write data.
REQ-008 gnt_a  out  1, rvalid_a  out  1, rdata_a  out  BW: CPU port grant pulse, read-valid pulse and read data.
REQ-009 req_b, we_b, lock_b  in  1 each: loader/debug port request, write-enable and bus lock.
REQ-010 addr_b  in  AW, wdata_b  in  BW: loader port address and write data.
REQ-011 gnt_b, rvalid_b  out  1 each, rdata_b  out  BW: loader port grant, read-valid and read data.
REQ-012 mem_addr  out  AW, mem_data  out  BW, mem_wren  out  1: MM address, write data and write enable.
REQ-013 mem_q  in  BW: MM read data, valid one cycle after the address is presented.

Function
REQ-014 FSM states: IDLE, ACC_A, ACC_B, HOLD_B.
REQ-015 In IDLE, on a clock edge with a request pending, the winner's addr/we/wdata are captured into internal registers and the FSM enters ACC_x.
REQ-016 Arbitration in IDLE is round-robin.
- If req_a and req_b are both high, the port not served last wins.
- If only one request is high, that port wins.
- If neither is high, the FSM stays in IDLE.
REQ-017 In ACC_x, the arbiter drives:
- mem_addr and mem_data from the captured registers;
- mem_wren equal to the captured we;
- gnt_x high for exactly this one cycle.
REQ-018 Outside ACC_A and ACC_B: mem_wren is 0, mem_addr and mem_data hold their last values, and both gnt signals are 0.
REQ-019 For a read granted in ACC_x, rvalid_x is high for exactly the next cycle, and rdata_x equals mem_q in that cycle.
- Writes produce no rvalid.
- rdata_x holds its value between pulses.
REQ-020 Request latency: req sampled at edge N, gnt in cycle N+1, read data valid in cycle N+2.
- Unlocked throughput is one access per two cycles.
REQ-021 ACC_A always returns to IDLE.
REQ-022 ACC_B goes to HOLD_B if lock_b is high and the burst counter is below MAX_BURST; otherwise it goes to IDLE.
REQ-023 HOLD_B transitions:
- req_b high: capture port B and enter ACC_B, giving back-to-back one-per-two-cycle B accesses while port A waits;
- req_b low and lock_b low: enter IDLE;
- req_b low and lock_b high: stay in HOLD_B.
REQ-024 The burst counter (width ceil(log2(MAX_BURST+1))):
- increments on each ACC_B entered from HOLD_B;
- resets to 1 on ACC_B entered from IDLE;
- clears in IDLE.
REQ-025 On reaching MAX_BURST, ACC_B exits to IDLE and marks B as last served, so a pending req_a wins next.
REQ-026 Requesters hold req/addr/we/wdata stable until they see gnt and drop or renew req in the gnt cycle.
- Request inputs in the gnt cycle are ignored.
- A request dropped before capture produces no access.
REQ-027 lock_b asserted while B does not own the bus has no effect until B is granted.

Reset
REQ-028 On an edge with rstn=0, the following are cleared:
- FSM to IDLE;
- gnt_a, gnt_b, rvalid_a, rvalid_b, mem_wren to 0;
- mem_addr, mem_data, rdata_a, rdata_b and capture registers to 0;
- burst counter to 0;
- last-served to B, so port A wins the first contention.
REQ-029 Reset during ACC_x still lets MM complete the write it samples at that edge.
- No rvalid is issued for an interrupted read.
- mem_wren is 0 from the following cycle.

Structure
REQ-030 A shared package holds the FSM state encoding (2 bits), the port-select constants, and default widths BW=16, AW=9.
REQ-031 There is no sub-module; FSM, capture registers, burst counter and read-return pipeline are all in mem_arb.

Verification
REQ-032 Single read: req_a=1, addr_a=0x010, MM[0x010]=0x1234 -> gnt_a in cycle 1, rvalid_a in cycle 2 with rdata_a=0x1234, mem_wren 0 throughout.
REQ-033 Contention after reset: req_a and req_b both high in the same cycle -> gnt_a first, gnt_b two cycles later; repeated contention alternates A, B, A.
REQ-034 Locked burst: lock_b=1 with 10 B writes to 0x100..0x109, and req_a high from the start.
- Exactly 8 gnt_b pulses occur, then gnt_a.
- The remaining 2 B writes follow the A access.
- MM holds all 10 words.
REQ-035 Write then read-back: B writes 0xBEEF to 0x1FF (address wrap boundary), then A reads 0x1FF -> rdata_a=0xBEEF.
REQ-036 Reset mid-access: rstn=0 during ACC_A for a read.
- No rvalid_a.
- All outputs 0 on the next cycle.
- Subsequent contention grants A first.
